// File: rtl/gpio_ctrl.sv
// GPIO controller: register port, synchronized/debounced inputs, edge events
// and sticky W1C interrupt status with a level interrupt output.
module gpio_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] dir_ctrl,
    output logic [WIDTH-1:0] irq_event,
    output logic             irq
);

    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE);

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] status;

    logic [WIDTH-1:0] ff1;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] prev;
    logic [7:0]       cnt [WIDTH];

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] event_set;
    logic [WIDTH-1:0] status_clr;
    logic [WIDTH-1:0] rd_mux;

    assign data_out = out_reg;
    assign dir_ctrl = dir_reg;

    always_comb begin
        rise       = debounced & ~prev;
        fall       = ~debounced & prev;
        event_set  = irq_en & ((rise & rise_en) | (fall & fall_en));
        status_clr = (wr_en && (wr_addr == 3'd6)) ? wr_data : '0;
    end

    // Read mux sees register values before any same-cycle write lands.
    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            3'd0:    rd_mux = out_reg;
            3'd1:    rd_mux = dir_reg;
            3'd2:    rd_mux = debounced;
            3'd3:    rd_mux = irq_en;
            3'd4:    rd_mux = rise_en;
            3'd5:    rd_mux = fall_en;
            3'd6:    rd_mux = status;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= '0;
            dir_reg <= '0;
            irq_en  <= '0;
            rise_en <= '0;
            fall_en <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                3'd0:    out_reg <= wr_data;
                3'd1:    dir_reg <= wr_data;
                3'd3:    irq_en  <= wr_data;
                3'd4:    rise_en <= wr_data;
                3'd5:    fall_en <= wr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

    // A pin is accepted only after sync has differed from debounced for DEBOUNCE cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff1       <= '0;
            sync      <= '0;
            debounced <= '0;
            prev      <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            ff1  <= data_in;
            sync <= ff1;
            prev <= debounced;
            for (int i = 0; i < WIDTH; i++) begin
                if (DEBOUNCE == 0) begin
                    debounced[i] <= sync[i];
                    cnt[i]       <= '0;
                end else if (sync[i] == debounced[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LIMIT) begin
                    debounced[i] <= sync[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    // Set beats clear when a new event and a W1C hit the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_event <= '0;
            status    <= '0;
            irq       <= 1'b0;
        end else begin
            irq_event <= event_set;
            status    <= (status & ~status_clr) | event_set;
            irq       <= |status;
        end
    end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl (WIDTH=8, DEBOUNCE=4):
// register access, debounce latency, glitch rejection, W1C and reset.
module tb_gpio_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] dir_ctrl;
    logic [7:0] irq_event;
    logic       irq;

    int total;
    int bad;

    gpio_ctrl #(.WIDTH(8), .DEBOUNCE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .data_in   (data_in),
        .data_out  (data_out),
        .dir_ctrl  (dir_ctrl),
        .irq_event (irq_event),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_write(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] addr, output logic [7:0] data, output logic valid);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = addr;
        @(negedge clk);
        rd_en   = 1'b0;
        data    = rd_data;
        valid   = rd_valid;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       v;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (data_out !== 8'h00 || dir_ctrl !== 8'h00 || irq !== 1'b0 || rd_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got out=%h dir=%h irq=%b rv=%b, want 00 00 0 0",
                     data_out, dir_ctrl, irq, rd_valid);
        end
        for (int a = 0; a < 8; a++) begin
            do_read(3'(a), d, v);
            total++;
            if (v !== 1'b1 || d !== 8'h00) begin
                bad++;
                $display("[TB] FAIL reset_read addr %0d: got valid=%b data=%h, want 1 00", a, v, d);
            end
        end
        @(negedge clk);
        total++;
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL read_valid_drop: got %b, want 0", rd_valid);
        end
    endtask

    task automatic test_regs();
        logic [7:0] d;
        logic       v;
        do_write(3'd1, 8'hF0);
        total++;
        if (dir_ctrl !== 8'hF0) begin
            bad++;
            $display("[TB] FAIL dir_write: got %h, want f0", dir_ctrl);
        end
        do_write(3'd0, 8'hA5);
        total++;
        if (data_out !== 8'hA5) begin
            bad++;
            $display("[TB] FAIL out_write: got %h, want a5", data_out);
        end
        do_read(3'd1, d, v);
        total++;
        if (v !== 1'b1 || d !== 8'hF0) begin
            bad++;
            $display("[TB] FAIL dir_read: got valid=%b data=%h, want 1 f0", v, d);
        end
        do_read(3'd0, d, v);
        total++;
        if (v !== 1'b1 || d !== 8'hA5) begin
            bad++;
            $display("[TB] FAIL out_read: got valid=%b data=%h, want 1 a5", v, d);
        end
        do_write(3'd7, 8'hFF);
        do_write(3'd2, 8'hFF);
        do_read(3'd7, d, v);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reserved_read: got %h, want 00", d);
        end
        do_read(3'd2, d, v);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("[TB] FAIL in_ro_read: got %h, want 00", d);
        end
    endtask

    task automatic test_rw_collision();
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 8'h3C;
        rd_en   = 1'b1;
        rd_addr = 3'd0;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || data_out !== 8'h3C) begin
            bad++;
            $display("[TB] FAIL rw_same_addr: got rv=%b rd=%h out=%h, want 1 a5 3c",
                     rd_valid, rd_data, data_out);
        end
    endtask

    task automatic test_rise_latency();
        logic [7:0] d;
        logic       v;
        do_write(3'd3, 8'h01);
        do_write(3'd4, 8'h01);
        @(negedge clk);
        data_in[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            total++;
            if (irq_event[0] !== (k == 8)) begin
                bad++;
                $display("[TB] FAIL rise_event edge %0d: got %b, want %b", k, irq_event[0], (k == 8));
            end
            total++;
            if (irq !== (k >= 9)) begin
                bad++;
                $display("[TB] FAIL rise_irq edge %0d: got %b, want %b", k, irq, (k >= 9));
            end
        end
        do_read(3'd2, d, v);
        total++;
        if (d !== 8'h01) begin
            bad++;
            $display("[TB] FAIL in_read: got %h, want 01", d);
        end
        do_read(3'd6, d, v);
        total++;
        if (d !== 8'h01) begin
            bad++;
            $display("[TB] FAIL rise_status: got %h, want 01", d);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        logic       v;
        int         ev_cnt;
        @(negedge clk);
        data_in[0] = 1'b0;
        repeat (12) @(negedge clk);
        do_write(3'd6, 8'h01);
        repeat (2) @(negedge clk);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL glitch_pre_irq: got %b, want 0", irq);
        end
        data_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        data_in[0] = 1'b0;
        ev_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (irq_event[0] === 1'b1) ev_cnt++;
        end
        total++;
        if (ev_cnt !== 0) begin
            bad++;
            $display("[TB] FAIL glitch_events: got %0d, want 0", ev_cnt);
        end
        do_read(3'd6, d, v);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("[TB] FAIL glitch_status: got %h, want 00", d);
        end
    endtask

    task automatic test_fall();
        logic [7:0] d;
        logic       v;
        int         ev_cnt;
        do_write(3'd5, 8'h02);
        do_write(3'd3, 8'h02);
        @(negedge clk);
        data_in[1] = 1'b1;
        ev_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (irq_event[1] === 1'b1) ev_cnt++;
        end
        do_read(3'd6, d, v);
        total++;
        if (ev_cnt !== 0 || d !== 8'h00) begin
            bad++;
            $display("[TB] FAIL fall_on_rise: got events=%0d status=%h, want 0 00", ev_cnt, d);
        end
        data_in[1] = 1'b0;
        ev_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (irq_event[1] === 1'b1) ev_cnt++;
        end
        do_read(3'd6, d, v);
        total++;
        if (ev_cnt !== 1 || d !== 8'h02 || irq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL fall_event: got events=%0d status=%h irq=%b, want 1 02 1", ev_cnt, d, irq);
        end
        do_write(3'd6, 8'h02);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL w1c_irq_hold: got %b, want 1", irq);
        end
        @(negedge clk);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL w1c_irq_drop: got %b, want 0", irq);
        end
        do_read(3'd6, d, v);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("[TB] FAIL w1c_status: got %h, want 00", d);
        end
    endtask

    task automatic test_set_wins();
        logic [7:0] d;
        logic       v;
        do_write(3'd3, 8'h03);
        @(negedge clk);
        data_in[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 7) begin
                wr_en   = 1'b1;
                wr_addr = 3'd6;
                wr_data = 8'h01;
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        total++;
        if (irq_event[0] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL setwins_event: got %b, want 1", irq_event[0]);
        end
        do_read(3'd6, d, v);
        total++;
        if (d !== 8'h01) begin
            bad++;
            $display("[TB] FAIL setwins_status: got %h, want 01", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic       v;
        do_write(3'd3, 8'hFF);
        do_write(3'd4, 8'hFF);
        @(negedge clk);
        data_in = 8'hFF;
        repeat (12) @(negedge clk);
        do_read(3'd6, d, v);
        total++;
        if (d !== 8'hFF || irq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL prereset_status: got status=%h irq=%b, want ff 1", d, irq);
        end
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = 3'd6;
        rst     = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || data_out !== 8'h00 ||
            dir_ctrl !== 8'h00 || irq !== 1'b0 || irq_event !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_mid: got rv=%b rd=%h out=%h dir=%h irq=%b ev=%h, want all 0",
                     rd_valid, rd_data, data_out, dir_ctrl, irq, irq_event);
        end
        rst = 1'b0;
        do_read(3'd6, d, v);
        total++;
        if (v !== 1'b1 || d !== 8'h00) begin
            bad++;
            $display("[TB] FAIL postreset_status: got valid=%b data=%h, want 1 00", v, d);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 8'h00;
        rd_en   = 1'b0;
        rd_addr = 3'd0;
        data_in = 8'h00;
        test_reset();
        test_regs();
        test_rw_collision();
        test_rise_latency();
        test_glitch();
        test_fall();
        test_set_wins();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
